// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width
// and FSM state encodings.
package pipe_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 4;
   localparam int NUM_REGS  = 1 << REG_IDX_W;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_GSTALL = 2'd2,
      ST_UNUSED = 2'd3
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// Per-register and condition-code in-flight counters. Incremented on issue,
// decremented on retire; the pending flags are registered alongside the counts.
module hz_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue,
   input  logic                          issue_reg_wen,
   input  logic                          issue_cc_wen,
   input  logic [REG_IDX_W-1:0]          issue_idx,
   input  logic                          retire,
   input  logic                          retire_reg_wen,
   input  logic                          retire_cc_wen,
   input  logic [REG_IDX_W-1:0]          retire_idx,
   output logic [NUM_REGS*CNT_WIDTH-1:0] counts,
   output logic [CNT_WIDTH-1:0]          cc_count,
   output logic [NUM_REGS-1:0]           pending,
   output logic                          cc_pending
);

   logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
   logic [CNT_WIDTH-1:0] cc_d;

   // A same-cycle issue and retire cancel; a retire at zero is dropped.
   function automatic logic [CNT_WIDTH-1:0] step(input logic [CNT_WIDTH-1:0] cur,
                                                 input logic inc, input logic dec);
      if (inc && !dec)
         return cur + 1'b1;
      if (dec && !inc && cur != '0)
         return cur - 1'b1;
      return cur;
   endfunction

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = step(cnt_q[r],
                         issue && issue_reg_wen && (issue_idx == r[REG_IDX_W-1:0]),
                         retire && retire_reg_wen && (retire_idx == r[REG_IDX_W-1:0]));
      end
      cc_d = step(cc_count, issue && issue_cc_wen, retire && retire_cc_wen);
   end

   always_comb begin
      counts = '0;
      for (int r = 0; r < NUM_REGS; r++)
         counts[r*CNT_WIDTH +: CNT_WIDTH] = cnt_q[r];
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            cnt_q[r] <= '0;
         cc_count   <= '0;
         pending    <= '0;
         cc_pending <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r]   <= cnt_d[r];
            pending[r] <= |cnt_d[r];
         end
         cc_count   <= cc_d;
         cc_pending <= |cc_d;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch-flush / GPU-stall FSM plus data-hazard
// stall generation on top of the in-flight register scoreboard.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 2
) (
   input  logic                 I_CLOCK,
   input  logic                 I_RESET,
   input  logic                 I_LOCK,
   input  logic                 I_DE_Valid,
   input  logic [REG_IDX_W-1:0] I_DE_Src1Idx,
   input  logic [REG_IDX_W-1:0] I_DE_Src2Idx,
   input  logic                 I_DE_Src1Used,
   input  logic                 I_DE_Src2Used,
   input  logic [REG_IDX_W-1:0] I_DE_DestRegIdx,
   input  logic                 I_DE_RegWEn,
   input  logic                 I_DE_CCWEn,
   input  logic                 I_DE_ReadsCC,
   input  logic                 I_BranchAddrSelect_Signal,
   input  logic                 I_GPUStallSignal,
   input  logic                 I_WB_Valid,
   input  logic                 I_WB_RegWEn,
   input  logic                 I_WB_CCWEn,
   input  logic [REG_IDX_W-1:0] I_WB_DestRegIdx,
   output logic                 O_DEStall_Signal,
   output logic                 O_Flush,
   output logic [1:0]           O_State,
   output logic [NUM_REGS-1:0]  O_PendingRegMask,
   output logic                 O_CCPending
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t                       state_q, state_d;
   logic [2:0]                   fcnt_q, fcnt_d;
   logic                         flush_q;
   logic                         hazard, issue;
   logic [NUM_REGS*CNT_WIDTH-1:0] counts;
   logic [CNT_WIDTH-1:0]         cc_count;
   logic [CNT_WIDTH-1:0]         cnt [NUM_REGS];

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++)
         cnt[r] = counts[r*CNT_WIDTH +: CNT_WIDTH];
   end

   // Sources must not be in flight; a destination counter at max cannot take another write.
   always_comb begin
      hazard = I_DE_Valid &
               ((I_DE_Src1Used & (cnt[I_DE_Src1Idx] != '0)) |
                (I_DE_Src2Used & (cnt[I_DE_Src2Idx] != '0)) |
                (I_DE_ReadsCC  & (cc_count != '0)) |
                (I_DE_RegWEn   & (cnt[I_DE_DestRegIdx] == CNT_MAX)) |
                (I_DE_CCWEn    & (cc_count == CNT_MAX)));
      O_DEStall_Signal = I_RESET | hazard | (state_q == ST_GSTALL) |
                         I_GPUStallSignal | ~I_LOCK;
      issue = I_DE_Valid & I_LOCK & ~O_DEStall_Signal &
              (state_q == ST_RUN) & ~I_BranchAddrSelect_Signal;
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_RUN: begin
            if (I_BranchAddrSelect_Signal) begin
               state_d = ST_FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end else if (I_GPUStallSignal) begin
               state_d = ST_GSTALL;
            end
         end
         ST_FLUSH: begin
            fcnt_d = fcnt_q - 1'b1;
            if (fcnt_q <= 3'd1) begin
               fcnt_d  = 3'd0;
               state_d = I_GPUStallSignal ? ST_GSTALL : ST_RUN;
            end
         end
         ST_GSTALL: begin
            if (!I_GPUStallSignal)
               state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = 3'd0;
         end
      endcase
   end

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         state_q <= ST_RUN;
         fcnt_q  <= 3'd0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         flush_q <= (state_d == ST_FLUSH);
      end
   end

   assign O_Flush = flush_q;
   assign O_State = state_q;

   hz_scoreboard #(.CNT_WIDTH(CNT_WIDTH)) u_scoreboard (
      .clk            (I_CLOCK),
      .rst            (I_RESET),
      .issue          (issue),
      .issue_reg_wen  (I_DE_RegWEn),
      .issue_cc_wen   (I_DE_CCWEn),
      .issue_idx      (I_DE_DestRegIdx),
      .retire         (I_WB_Valid),
      .retire_reg_wen (I_WB_RegWEn),
      .retire_cc_wen  (I_WB_CCWEn),
      .retire_idx     (I_WB_DestRegIdx),
      .counts         (counts),
      .cc_count       (cc_count),
      .pending        (O_PendingRegMask),
      .cc_pending     (O_CCPending)
   );

endmodule
